// File: rtl/sfifo_pkg.sv
// Shared definitions for the synchronous FIFO write-side blocks: the arbiter
// state encoding and the width helper used for pointers and counters.
package sfifo_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Bits needed to index 'value' items; never less than 1.
  function automatic int clog2(input int value);
    int w;
    int v;
    w = 0;
    v = value - 1;
    while (v > 0) begin
      w++;
      v = v >>> 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sfifo_wr_arbiter_if.sv
// Bundle between the write producers / FIFO write controller (master side)
// and the write-port arbiter (slave side).
interface sfifo_wr_arbiter_if #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 8
);

  logic [NumReq-1:0]           Req;
  logic [NumReq*DataWidth-1:0] WrData;
  logic                        FIFOFull;
  logic [NumReq-1:0]           Grant;
  logic [NumReq-1:0]           Ack;
  logic                        FIFOWrReq;
  logic [DataWidth-1:0]        FIFOWrData;
  logic                        Busy;

  modport master (
    output Req, WrData, FIFOFull,
    input  Grant, Ack, FIFOWrReq, FIFOWrData, Busy
  );

  modport slave (
    input  Req, WrData, FIFOFull,
    output Grant, Ack, FIFOWrReq, FIFOWrData, Busy
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping past the top index back to zero.
module rr_priority_pick
  import sfifo_pkg::*;
#(
  parameter int NumReq = 4
) (
  input  logic [NumReq-1:0]        req,
  input  logic [clog2(NumReq)-1:0] ptr,
  output logic [NumReq-1:0]        winner,
  output logic                     any_req
);

  int   idx;
  logic found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int off = 0; off < NumReq; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NumReq) idx = idx - NumReq;
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/sfifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NumReq producers,
// granting bursts of up to MaxBurst beats with per-beat full back-pressure.
module sfifo_wr_arbiter
  import sfifo_pkg::*;
#(
  parameter int NumReq    = 4,
  parameter int DataWidth = 8,
  parameter int MaxBurst  = 4
) (
  input  logic               clk,
  input  logic               reset,
  sfifo_wr_arbiter_if.slave  bus
);

  localparam int PtrW = clog2(NumReq);
  localparam int CntW = clog2(MaxBurst) + 1;

  state_t            state, state_n;
  logic [NumReq-1:0] grant, grant_n;
  logic [PtrW-1:0]   ptr, ptr_n;
  logic [CntW-1:0]   beat_cnt, beat_n;

  logic [NumReq-1:0]    winner;
  logic                 any_req;
  logic [PtrW-1:0]      owner;
  logic [PtrW-1:0]      ptr_after_owner;
  logic                 req_owner;
  logic                 xfer;
  logic                 last_beat;
  logic [DataWidth-1:0] wr_data;

  rr_priority_pick #(
    .NumReq (NumReq)
  ) u_pick (
    .req     (bus.Req),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    owner   = '0;
    wr_data = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (grant[i]) begin
        owner   = PtrW'(i);
        wr_data = wr_data | bus.WrData[i*DataWidth +: DataWidth];
      end
    end
  end

  // Grant is zero outside BURST, so these gate themselves in IDLE.
  assign req_owner       = |(bus.Req & grant);
  assign xfer            = (state == ST_BURST) && req_owner && !bus.FIFOFull;
  assign last_beat       = (beat_cnt == CntW'(MaxBurst - 1));
  assign ptr_after_owner = (owner == PtrW'(NumReq - 1)) ? '0 : owner + PtrW'(1);

  assign bus.Ack        = grant & bus.Req & {NumReq{!bus.FIFOFull}};
  assign bus.FIFOWrReq  = xfer;
  assign bus.FIFOWrData = wr_data;
  assign bus.Grant      = grant;
  assign bus.Busy       = (state == ST_BURST);

  always_comb begin
    state_n = state;
    grant_n = grant;
    ptr_n   = ptr;
    beat_n  = beat_cnt;
    unique case (state)
      ST_IDLE: begin
        if (any_req) begin
          grant_n = winner;
          beat_n  = '0;
          state_n = ST_BURST;
        end
      end
      ST_BURST: begin
        if (!req_owner || (xfer && last_beat)) begin
          grant_n = '0;
          ptr_n   = ptr_after_owner;
          beat_n  = '0;
          state_n = ST_IDLE;
        end else if (xfer) begin
          beat_n  = beat_cnt + CntW'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        grant_n = '0;
        beat_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      grant    <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      ptr      <= ptr_n;
      beat_cnt <= beat_n;
    end
  end

endmodule

// File: tb/tb_sfifo_wr_arbiter.sv
// Directed bench for sfifo_wr_arbiter: grant latency, round-robin order,
// early withdrawal, full back-pressure and reset mid-burst.
module tb_sfifo_wr_arbiter;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  sfifo_wr_arbiter_if #(.NumReq(4), .DataWidth(8)) bus ();

  sfifo_wr_arbiter #(
    .NumReq    (4),
    .DataWidth (8),
    .MaxBurst  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  logic [3:0] rr_grant [5];
  logic [7:0] rr_data  [5];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rr_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_data  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    reset        = 1'b0;
    bus.Req      = '0;
    bus.FIFOFull = 1'b0;
    bus.WrData   = 32'h44332211;
    tick();
    tick();
    check("rst_grant", 32'(bus.Grant), 32'h0);
    check("rst_busy", 32'(bus.Busy), 32'h0);
    check("rst_wrreq", 32'(bus.FIFOWrReq), 32'h0);
    check("rst_ack", 32'(bus.Ack), 32'h0);
    check("rst_data", 32'(bus.FIFOWrData), 32'h0);
    reset = 1'b1;

    // single requester: 4 beats, bubble, regrant
    bus.Req = 4'b0010;
    #1;
    check("single_no_grant_yet", 32'(bus.Grant), 32'h0);
    tick();
    check("single_busy", 32'(bus.Busy), 32'h1);
    for (int b = 0; b < 4; b++) begin
      check("single_grant", 32'(bus.Grant), 32'h2);
      check("single_ack", 32'(bus.Ack), 32'h2);
      check("single_wrreq", 32'(bus.FIFOWrReq), 32'h1);
      check("single_data", 32'(bus.FIFOWrData), 32'h22);
      tick();
    end
    check("single_bubble_grant", 32'(bus.Grant), 32'h0);
    check("single_bubble_busy", 32'(bus.Busy), 32'h0);
    check("single_bubble_ack", 32'(bus.Ack), 32'h0);
    tick();
    check("single_regrant", 32'(bus.Grant), 32'h2);
    bus.Req = '0;
    #1;
    check("single_withdraw_ack", 32'(bus.Ack), 32'h0);
    tick();
    do_reset();

    // round-robin with all requesting
    bus.Req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      for (int b = 0; b < 4; b++) begin
        check("rr_grant", 32'(bus.Grant), 32'(rr_grant[k]));
        check("rr_ack", 32'(bus.Ack), 32'(rr_grant[k]));
        check("rr_data", 32'(bus.FIFOWrData), 32'(rr_data[k]));
        if (b < 3) tick();
      end
      tick();
      check("rr_bubble", 32'(bus.Grant), 32'h0);
    end
    bus.Req = '0;
    tick();
    do_reset();

    // early withdrawal by requester 2 after two beats
    bus.Req = 4'b0100;
    tick();
    check("wd_ack1", 32'(bus.Ack), 32'h4);
    tick();
    check("wd_ack2", 32'(bus.Ack), 32'h4);
    tick();
    bus.Req = '0;
    #1;
    check("wd_drop_ack", 32'(bus.Ack), 32'h0);
    check("wd_drop_wrreq", 32'(bus.FIFOWrReq), 32'h0);
    check("wd_drop_grant", 32'(bus.Grant), 32'h4);
    tick();
    check("wd_released", 32'(bus.Grant), 32'h0);
    bus.Req = 4'b0101;
    tick();
    check("wd_wrap_grant", 32'(bus.Grant), 32'h1);
    check("wd_wrap_data", 32'(bus.FIFOWrData), 32'h11);
    bus.Req = '0;
    tick();
    check("wd_idle", 32'(bus.Grant), 32'h0);

    // full back-pressure mid-burst (pointer now 1)
    bus.Req = 4'b0010;
    tick();
    check("full_beat1", 32'(bus.Ack), 32'h2);
    tick();
    check("full_beat2", 32'(bus.Ack), 32'h2);
    tick();
    for (int s = 0; s < 3; s++) begin
      bus.FIFOFull = 1'b1;
      #1;
      check("full_stall_ack", 32'(bus.Ack), 32'h0);
      check("full_stall_wrreq", 32'(bus.FIFOWrReq), 32'h0);
      check("full_stall_grant", 32'(bus.Grant), 32'h2);
      check("full_stall_data", 32'(bus.FIFOWrData), 32'h22);
      tick();
    end
    bus.FIFOFull = 1'b0;
    #1;
    check("full_beat3", 32'(bus.Ack), 32'h2);
    check("full_beat3_wrreq", 32'(bus.FIFOWrReq), 32'h1);
    tick();
    check("full_beat4", 32'(bus.Ack), 32'h2);
    tick();
    check("full_released", 32'(bus.Grant), 32'h0);
    bus.Req = '0;
    tick();

    // reset during beat 2 of requester 3 (pointer now 2)
    bus.Req = 4'b1000;
    tick();
    check("rst3_beat1", 32'(bus.Ack), 32'h8);
    tick();
    check("rst3_beat2", 32'(bus.Ack), 32'h8);
    reset = 1'b0;
    tick();
    check("rst3_grant", 32'(bus.Grant), 32'h0);
    check("rst3_busy", 32'(bus.Busy), 32'h0);
    check("rst3_wrreq", 32'(bus.FIFOWrReq), 32'h0);
    check("rst3_data", 32'(bus.FIFOWrData), 32'h0);
    reset   = 1'b1;
    bus.Req = 4'b1001;
    tick();
    check("rst3_ptr0_grant", 32'(bus.Grant), 32'h1);
    bus.Req = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
